// File: rtl/program_loader_if.sv
// Host-link and memory-port bundle for program_loader.
//   rx_data/rx_valid/rx_ready  : byte stream from the host (valid/ready)
//   addr_ext/wdata_ext/wen_ext : instruction memory write port (32-bit words)
//   addr_ext_2/wdata_ext_2/wen_ext_2 : data memory write port (64-bit words)
//   cpu_enable, busy, err      : loader status towards the cpu / system
// master = the loader itself, slave = host link plus memories/cpu.
interface program_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [63:0] addr_ext;
  logic [31:0] wdata_ext;
  logic        wen_ext;
  logic [63:0] addr_ext_2;
  logic [63:0] wdata_ext_2;
  logic        wen_ext_2;
  logic        cpu_enable;
  logic        busy;
  logic        err;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, addr_ext, wdata_ext, wen_ext,
    output addr_ext_2, wdata_ext_2, wen_ext_2,
    output cpu_enable, busy, err
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, addr_ext, wdata_ext, wen_ext,
    input  addr_ext_2, wdata_ext_2, wen_ext_2,
    input  cpu_enable, busy, err
  );
endinterface

// File: rtl/program_loader.sv
// Boot-time loader: parses a byte stream (magic 0xA5, n_i, n_d, instruction
// words, data words), writes the words into instruction/data memory and then
// starts the cpu through cpu_enable.
// Ports:
//   clk  : single clock
//   rst  : synchronous active-high reset
//   bus  : program_loader_if.master (stream input, both memory write ports,
//          cpu_enable/busy/err status)
module program_loader #(
  parameter int IMEM_WORDS = 512,
  parameter int DMEM_WORDS = 1024
) (
  input  logic             clk,
  input  logic             rst,
  program_loader_if.master bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_IMEM = 3'd2;
  localparam logic [2:0] S_DMEM = 3'd3;
  localparam logic [2:0] S_RUN  = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam logic [7:0]  MAGIC    = 8'hA5;
  localparam logic [16:0] IMEM_LIM = 17'(IMEM_WORDS);
  localparam logic [16:0] DMEM_LIM = 17'(DMEM_WORDS);

  logic [2:0]  state_reg, state_next;
  logic [1:0]  hdr_cnt_reg, hdr_cnt_next;
  logic [15:0] n_i_reg, n_i_next;
  logic [15:0] n_d_reg, n_d_next;
  logic [2:0]  byte_cnt_reg, byte_cnt_next;
  logic [15:0] word_idx_reg, word_idx_next;
  logic [63:0] word_reg, word_next;
  logic [63:0] addr_i_reg, addr_i_next;
  logic [31:0] wdata_i_reg, wdata_i_next;
  logic        wen_i_reg, wen_i_next;
  logic [63:0] addr_d_reg, addr_d_next;
  logic [63:0] wdata_d_reg, wdata_d_next;
  logic        wen_d_reg, wen_d_next;
  logic        cpu_enable_reg, cpu_enable_next;
  logic        rx_ready_reg, rx_ready_next;

  logic        accept;
  logic [63:0] word_merged;
  logic [15:0] nd_full;

  assign accept = bus.rx_valid && rx_ready_reg;

  always_comb begin
    state_next    = state_reg;
    hdr_cnt_next  = hdr_cnt_reg;
    n_i_next      = n_i_reg;
    n_d_next      = n_d_reg;
    byte_cnt_next = byte_cnt_reg;
    word_idx_next = word_idx_reg;
    word_next     = word_reg;
    addr_i_next   = addr_i_reg;
    wdata_i_next  = wdata_i_reg;
    wen_i_next    = 1'b0;
    addr_d_next   = addr_d_reg;
    wdata_d_next  = wdata_d_reg;
    wen_d_next    = 1'b0;

    // Partial word with the incoming byte dropped into its lane; this is the
    // complete word on the last byte, so the write never waits a cycle.
    word_merged = word_reg;
    word_merged[{byte_cnt_reg, 3'b000} +: 8] = bus.rx_data;
    // Full n_d as it will be once the 4th header byte lands.
    nd_full = {bus.rx_data, n_d_reg[7:0]};

    if (accept) begin
      case (state_reg)
        S_IDLE: begin
          if (bus.rx_data == MAGIC) begin
            state_next   = S_HDR;
            hdr_cnt_next = 2'd0;
          end
        end
        S_HDR: begin
          hdr_cnt_next = hdr_cnt_reg + 2'd1;
          case (hdr_cnt_reg)
            2'd0: n_i_next[7:0]  = bus.rx_data;
            2'd1: n_i_next[15:8] = bus.rx_data;
            2'd2: n_d_next[7:0]  = bus.rx_data;
            default: begin
              n_d_next[15:8] = bus.rx_data;
              byte_cnt_next  = 3'd0;
              word_idx_next  = 16'd0;
              word_next      = 64'd0;
              if (({1'b0, n_i_reg} > IMEM_LIM) || ({1'b0, nd_full} > DMEM_LIM))
                state_next = S_ERR;
              else if (n_i_reg != 16'd0)
                state_next = S_IMEM;
              else if (nd_full != 16'd0)
                state_next = S_DMEM;
              else
                state_next = S_RUN;
            end
          endcase
        end
        S_IMEM: begin
          if (byte_cnt_reg == 3'd3) begin
            wen_i_next    = 1'b1;
            addr_i_next   = {46'd0, word_idx_reg, 2'b00};
            wdata_i_next  = word_merged[31:0];
            word_next     = 64'd0;
            byte_cnt_next = 3'd0;
            if (word_idx_reg == n_i_reg - 16'd1) begin
              word_idx_next = 16'd0;
              state_next    = (n_d_reg != 16'd0) ? S_DMEM : S_RUN;
            end else begin
              word_idx_next = word_idx_reg + 16'd1;
            end
          end else begin
            word_next     = word_merged;
            byte_cnt_next = byte_cnt_reg + 3'd1;
          end
        end
        S_DMEM: begin
          if (byte_cnt_reg == 3'd7) begin
            wen_d_next    = 1'b1;
            addr_d_next   = {45'd0, word_idx_reg, 3'b000};
            wdata_d_next  = word_merged;
            word_next     = 64'd0;
            byte_cnt_next = 3'd0;
            if (word_idx_reg == n_d_reg - 16'd1) begin
              word_idx_next = 16'd0;
              state_next    = S_RUN;
            end else begin
              word_idx_next = word_idx_reg + 16'd1;
            end
          end else begin
            word_next     = word_merged;
            byte_cnt_next = byte_cnt_reg + 3'd1;
          end
        end
        default: ;
      endcase
    end

    // Hold off cpu start while the final write strobe is going out, so the
    // last memory write is always seen before the cpu runs.
    cpu_enable_next = (state_next == S_RUN) && !wen_i_next && !wen_d_next;
    rx_ready_next   = (state_next == S_IDLE) || (state_next == S_HDR) ||
                      (state_next == S_IMEM) || (state_next == S_DMEM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      hdr_cnt_reg    <= 2'd0;
      n_i_reg        <= 16'd0;
      n_d_reg        <= 16'd0;
      byte_cnt_reg   <= 3'd0;
      word_idx_reg   <= 16'd0;
      word_reg       <= 64'd0;
      addr_i_reg     <= 64'd0;
      wdata_i_reg    <= 32'd0;
      wen_i_reg      <= 1'b0;
      addr_d_reg     <= 64'd0;
      wdata_d_reg    <= 64'd0;
      wen_d_reg      <= 1'b0;
      cpu_enable_reg <= 1'b0;
      rx_ready_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      hdr_cnt_reg    <= hdr_cnt_next;
      n_i_reg        <= n_i_next;
      n_d_reg        <= n_d_next;
      byte_cnt_reg   <= byte_cnt_next;
      word_idx_reg   <= word_idx_next;
      word_reg       <= word_next;
      addr_i_reg     <= addr_i_next;
      wdata_i_reg    <= wdata_i_next;
      wen_i_reg      <= wen_i_next;
      addr_d_reg     <= addr_d_next;
      wdata_d_reg    <= wdata_d_next;
      wen_d_reg      <= wen_d_next;
      cpu_enable_reg <= cpu_enable_next;
      rx_ready_reg   <= rx_ready_next;
    end
  end

  assign bus.rx_ready    = rx_ready_reg;
  assign bus.addr_ext    = addr_i_reg;
  assign bus.wdata_ext   = wdata_i_reg;
  assign bus.wen_ext     = wen_i_reg;
  assign bus.addr_ext_2  = addr_d_reg;
  assign bus.wdata_ext_2 = wdata_d_reg;
  assign bus.wen_ext_2   = wen_d_reg;
  assign bus.cpu_enable  = cpu_enable_reg;
  assign bus.busy        = (state_reg == S_HDR) || (state_reg == S_IMEM) ||
                           (state_reg == S_DMEM);
  assign bus.err         = (state_reg == S_ERR);

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed and $urandom streams,
// expected writes derived from the stream format by a reference parser.
module tb_program_loader;
  localparam int IMEM_WORDS = 512;
  localparam int DMEM_WORDS = 1024;

  typedef struct {
    bit          dmem;
    logic [63:0] addr;
    logic [63:0] data;
    int          end_idx;
  } exp_wr_t;

  typedef struct {
    bit          dmem;
    logic [63:0] addr;
    logic [63:0] data;
    int          cyc;
  } obs_wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  program_loader_if bus();

  program_loader #(.IMEM_WORDS(IMEM_WORDS), .DMEM_WORDS(DMEM_WORDS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] stream[$];
  exp_wr_t    exp_q[$];
  obs_wr_t    obs_q[$];
  int         acc_q[$];
  int         cyc = 0;
  int         en_cyc = -1;
  int         both_cnt = 0;
  bit         exp_err;
  int         en_idx;
  int         en_off;

  // Monitor: samples on the falling edge, away from the active edge.
  initial forever begin
    obs_wr_t o;
    @(negedge clk);
    cyc++;
    if (!rst) begin
      if (bus.rx_valid && bus.rx_ready) acc_q.push_back(cyc);
      if (bus.wen_ext) begin
        o.dmem = 1'b0; o.addr = bus.addr_ext; o.data = {32'd0, bus.wdata_ext}; o.cyc = cyc;
        obs_q.push_back(o);
      end
      if (bus.wen_ext_2) begin
        o.dmem = 1'b1; o.addr = bus.addr_ext_2; o.data = bus.wdata_ext_2; o.cyc = cyc;
        obs_q.push_back(o);
      end
      if (bus.wen_ext && bus.wen_ext_2) both_cnt++;
      if (bus.cpu_enable && en_cyc < 0) en_cyc = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] obs_data(input int j);
    if (j >= 0 && j < obs_q.size()) return obs_q[j].data;
    return 'x;
  endfunction

  function automatic logic [63:0] obs_addr(input int j);
    if (j >= 0 && j < obs_q.size()) return obs_q[j].addr;
    return 'x;
  endfunction

  function automatic logic [63:0] obs_kind(input int j);
    if (j >= 0 && j < obs_q.size()) return 64'(obs_q[j].dmem);
    return 'x;
  endfunction

  function automatic int obs_cyc(input int j);
    if (j >= 0 && j < obs_q.size()) return obs_q[j].cyc;
    return -1000;
  endfunction

  function automatic int acc_at(input int i);
    if (i >= 0 && i < acc_q.size()) return acc_q[i];
    return -2000;
  endfunction

  // Reference parser: walks the stream by the format rules and lists every
  // write that must happen plus the stream byte after which the cpu starts.
  task automatic build_expect();
    int p;
    int ni;
    int nd;
    logic [63:0] w;
    exp_wr_t e;
    exp_q.delete();
    p = 0;
    while (p < stream.size() && stream[p] != 8'hA5) p++;
    ni = int'({stream[p+2], stream[p+1]});
    nd = int'({stream[p+4], stream[p+3]});
    p = p + 5;
    exp_err = (ni > IMEM_WORDS) || (nd > DMEM_WORDS);
    en_idx = p - 1;
    en_off = 1;
    if (!exp_err) begin
      for (int k = 0; k < ni; k++) begin
        w = 64'd0;
        for (int b = 0; b < 4; b++) w = w | (64'(stream[p+b]) << (8 * b));
        e.dmem = 1'b0; e.addr = 64'(k * 4); e.data = w; e.end_idx = p + 3;
        exp_q.push_back(e);
        p = p + 4;
      end
      for (int k = 0; k < nd; k++) begin
        w = 64'd0;
        for (int b = 0; b < 8; b++) w = w | (64'(stream[p+b]) << (8 * b));
        e.dmem = 1'b1; e.addr = 64'(k * 8); e.data = w; e.end_idx = p + 7;
        exp_q.push_back(e);
        p = p + 8;
      end
      if (exp_q.size() > 0) begin
        en_idx = exp_q[exp_q.size()-1].end_idx;
        en_off = 2;
      end
    end
  endtask

  // Drives the stream with rx_valid asserted with probability duty% per cycle.
  task automatic send(input string tag, input int duty);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < stream.size() && guard < 30000) begin
      @(posedge clk); #1;
      bus.rx_data  = stream[i];
      bus.rx_valid = ($urandom_range(99) < duty);
      @(negedge clk);
      if (bus.rx_valid && bus.rx_ready) i++;
      guard++;
    end
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    check({tag, "_bytes_sent"}, 64'(i), 64'(stream.size()));
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    @(posedge clk); #1;
    check({tag, "_rst_rx_ready"},   64'(bus.rx_ready),   64'd0);
    check({tag, "_rst_wen"},        64'(bus.wen_ext),    64'd0);
    check({tag, "_rst_wen2"},       64'(bus.wen_ext_2),  64'd0);
    check({tag, "_rst_cpu_enable"}, 64'(bus.cpu_enable), 64'd0);
    check({tag, "_rst_busy"},       64'(bus.busy),       64'd0);
    check({tag, "_rst_err"},        64'(bus.err),        64'd0);
    check({tag, "_rst_addr"},       bus.addr_ext,        64'd0);
    check({tag, "_rst_addr2"},      bus.addr_ext_2,      64'd0);
    check({tag, "_rst_wdata"},      64'(bus.wdata_ext),  64'd0);
    check({tag, "_rst_wdata2"},     bus.wdata_ext_2,     64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    obs_q.delete();
    acc_q.delete();
    en_cyc = -1;
    both_cnt = 0;
  endtask

  task automatic verify(input string tag);
    int exp_en;
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_num_writes"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int j = 0; j < exp_q.size(); j++) begin
      check($sformatf("%s_w%0d_port", tag, j), obs_kind(j), 64'(exp_q[j].dmem));
      check($sformatf("%s_w%0d_addr", tag, j), obs_addr(j), exp_q[j].addr);
      check($sformatf("%s_w%0d_data", tag, j), obs_data(j), exp_q[j].data);
      check($sformatf("%s_w%0d_cycle", tag, j), 64'(obs_cyc(j)),
            64'(acc_at(exp_q[j].end_idx) + 1));
    end
    exp_en = exp_err ? -1 : acc_at(en_idx) + en_off;
    check({tag, "_enable_cycle"}, 64'(en_cyc), 64'(exp_en));
    check({tag, "_cpu_enable"}, 64'(bus.cpu_enable), 64'(!exp_err));
    check({tag, "_err"},        64'(bus.err),        64'(exp_err));
    check({tag, "_rx_ready"},   64'(bus.rx_ready),   64'd0);
    check({tag, "_busy"},       64'(bus.busy),       64'd0);
    check({tag, "_both_wen"},   64'(both_cnt),       64'd0);
  endtask

  initial begin
    logic [63:0] kv;
    int ni;
    int nd;
    int duty;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    // Basic load
    do_reset("init");
    stream = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h00,
               8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00,
               8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12};
    build_expect();
    send("basic", 100);
    verify("basic");
    check("basic_w0_const", obs_data(0), 64'h0000_0000_0010_0513);
    check("basic_w1_const", obs_data(1), 64'h0000_0000_0020_0593);
    check("basic_w2_const", obs_data(2), 64'h1234_5678_DEAD_BEEF);
    $display("txn basic: %0d writes observed, cpu_enable=%0b", obs_q.size(), bus.cpu_enable);

    // Junk before magic, zero counts
    do_reset("junk");
    stream = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
    build_expect();
    send("junk", 100);
    verify("junk");
    $display("txn junk: %0d writes observed, cpu_enable=%0b", obs_q.size(), bus.cpu_enable);

    // Over-capacity header, then 100 cycles of stimulus that must be ignored
    do_reset("overcap");
    stream = '{8'hA5, 8'h01, 8'h02, 8'h00, 8'h00};
    build_expect();
    send("overcap", 100);
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      bus.rx_valid = 1'($urandom_range(1));
      bus.rx_data  = 8'($urandom);
    end
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    verify("overcap");
    check("overcap_no_accepts", 64'(acc_q.size()), 64'(stream.size()));
    $display("txn overcap: err=%0b rx_ready=%0b", bus.err, bus.rx_ready);

    // Throttled basic load
    do_reset("throttle");
    stream = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h00,
               8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00,
               8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12};
    build_expect();
    send("throttle", 30);
    verify("throttle");
    $display("txn throttle: %0d writes observed, cpu_enable=%0b", obs_q.size(), bus.cpu_enable);

    // Reset mid-load, then a fresh single-word image
    do_reset("mid_pre");
    stream = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h00, 8'h13, 8'h05};
    send("mid_partial", 100);
    check("mid_busy_before_rst", 64'(bus.busy), 64'd1);
    do_reset("mid");
    stream = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    build_expect();
    send("mid_fresh", 100);
    verify("mid_fresh");
    check("mid_fresh_const", obs_data(0), 64'h0000_0000_4433_2211);
    $display("txn midload: %0d writes observed, cpu_enable=%0b", obs_q.size(), bus.cpu_enable);

    // Data capacity boundary
    do_reset("cap");
    stream = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h04};
    for (int k = 0; k < DMEM_WORDS; k++) begin
      kv = 64'(k);
      for (int b = 0; b < 8; b++) stream.push_back(kv[8*b +: 8]);
    end
    build_expect();
    send("cap", 100);
    verify("cap");
    check("cap_last_addr", obs_addr(obs_q.size() - 1), 64'h1FF8);
    check("cap_last_data", obs_data(obs_q.size() - 1), 64'h3FF);
    $display("txn capacity: %0d writes observed, cpu_enable=%0b", obs_q.size(), bus.cpu_enable);

    // Randomized images
    for (int t = 0; t < 4; t++) begin
      do_reset("rand");
      stream.delete();
      for (int j = 0; j < int'($urandom_range(3)); j++) stream.push_back(8'($urandom_range(8'hA4)));
      ni = int'($urandom_range(5));
      nd = int'($urandom_range(4));
      duty = int'($urandom_range(20, 100));
      stream.push_back(8'hA5);
      stream.push_back(ni[7:0]);
      stream.push_back(ni[15:8]);
      stream.push_back(nd[7:0]);
      stream.push_back(nd[15:8]);
      for (int j = 0; j < ni * 4 + nd * 8; j++) stream.push_back(8'($urandom));
      build_expect();
      send($sformatf("rand%0d", t), duty);
      verify($sformatf("rand%0d", t));
      $display("txn rand%0d: n_i=%0d n_d=%0d duty=%0d, %0d writes observed",
               t, ni, nd, duty, obs_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
